// File: rtl/alu_ctrl_if.sv
// Bundle of the request, ALU-drive and response ports around the ALU issue controller.
// The slave view belongs to the controller; the master view belongs to its environment.
interface alu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_decinst;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_imm;

    logic        alu_en;
    logic [11:0] alu_decinst;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_imm;
    logic [31:0] alu_rd;
    logic        alu_cmp;
    logic        alu_carry;
    logic        alu_is_rd;
    logic        alu_is_inst;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_cmp;
    logic        rsp_carry;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_decinst, req_rs1, req_rs2, req_imm,
        output req_ready,
        output alu_en, alu_decinst, alu_rs1, alu_rs2, alu_imm,
        input  alu_rd, alu_cmp, alu_carry, alu_is_rd, alu_is_inst,
        output rsp_valid, rsp_rd, rsp_wr, rsp_cmp, rsp_carry, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_decinst, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  alu_en, alu_decinst, alu_rs1, alu_rs2, alu_imm,
        output alu_rd, alu_cmp, alu_carry, alu_is_rd, alu_is_inst,
        input  rsp_valid, rsp_rd, rsp_wr, rsp_cmp, rsp_carry, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_ctrl.sv
// ALU issue controller: one op per handshake, LOAD (en low) then EXEC (en high) until
// the ALU reports completion or the EXEC timeout expires, then a held valid/ready response.
module alu_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic      clk,
    input  logic      reset,
    alu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        done_s;
    logic        tmo_s;
    logic [7:0]  cnt_r;

    logic [11:0] hold_decinst_r;
    logic [31:0] hold_rs1_r;
    logic [31:0] hold_rs2_r;
    logic [31:0] hold_imm_r;

    logic [31:0] rsp_rd_r;
    logic        rsp_wr_r;
    logic        rsp_cmp_r;
    logic        rsp_carry_r;
    logic        rsp_err_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and capture strobes; completion takes priority over timeout.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                state_nxt_s = EXEC;
            end
            EXEC: begin
                if (bus.alu_is_inst) begin
                    done_s      = 1'b1;
                    state_nxt_s = RESP;
                end else if (cnt_r == TMO_LAST) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // EXEC cycle counter: cleared in LOAD, saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (state_r == LOAD) begin
            cnt_r <= 8'd0;
        end else if ((state_r == EXEC) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operation holding registers; they feed the ALU and change only on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_decinst_r <= 12'd0;
            hold_rs1_r     <= 32'd0;
            hold_rs2_r     <= 32'd0;
            hold_imm_r     <= 32'd0;
        end else if (accept_s) begin
            hold_decinst_r <= bus.req_decinst;
            hold_rs1_r     <= bus.req_rs1;
            hold_rs2_r     <= bus.req_rs2;
            hold_imm_r     <= bus.req_imm;
        end else begin
            hold_decinst_r <= hold_decinst_r;
            hold_rs1_r     <= hold_rs1_r;
            hold_rs2_r     <= hold_rs2_r;
            hold_imm_r     <= hold_imm_r;
        end
    end

    // Response capture; alu_rd is masked unless the ALU claims it, so a floating bus never leaks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rd_r    <= 32'd0;
            rsp_wr_r    <= 1'b0;
            rsp_cmp_r   <= 1'b0;
            rsp_carry_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (done_s) begin
            rsp_rd_r    <= bus.alu_is_rd ? bus.alu_rd : 32'd0;
            rsp_wr_r    <= bus.alu_is_rd;
            rsp_cmp_r   <= bus.alu_cmp;
            rsp_carry_r <= bus.alu_carry;
            rsp_err_r   <= 1'b0;
        end else if (tmo_s) begin
            rsp_rd_r    <= 32'd0;
            rsp_wr_r    <= 1'b0;
            rsp_cmp_r   <= 1'b0;
            rsp_carry_r <= 1'b0;
            rsp_err_r   <= 1'b1;
        end else begin
            rsp_rd_r    <= rsp_rd_r;
            rsp_wr_r    <= rsp_wr_r;
            rsp_cmp_r   <= rsp_cmp_r;
            rsp_carry_r <= rsp_carry_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

    // Handshake and enable decode straight from the state register, so en drops in the first RESP cycle.
    assign bus.req_ready   = (state_r == IDLE);
    assign bus.alu_en      = (state_r == EXEC);
    assign bus.rsp_valid   = (state_r == RESP);

    assign bus.alu_decinst = hold_decinst_r;
    assign bus.alu_rs1     = hold_rs1_r;
    assign bus.alu_rs2     = hold_rs2_r;
    assign bus.alu_imm     = hold_imm_r;

    assign bus.rsp_rd      = rsp_rd_r;
    assign bus.rsp_wr      = rsp_wr_r;
    assign bus.rsp_cmp     = rsp_cmp_r;
    assign bus.rsp_carry   = rsp_carry_r;
    assign bus.rsp_err     = rsp_err_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a behavioural ALU with shift-dependent latency,
// a vector table of operations, plus hand-written backpressure and mid-EXEC reset sequences.
module tb_alu_ctrl;

    localparam logic [11:0] OP_ADD = 12'b000000110011;
    localparam logic [11:0] OP_BEQ = 12'b000001100011;
    localparam logic [11:0] OP_SLL = 12'b000010110011;
    localparam logic [11:0] OP_XOR = 12'b000100110011;
    localparam logic [11:0] OP_SRA = 12'b000101110011;
    localparam logic [11:0] OP_BAD = 12'hFFF;

    typedef struct {
        logic [11:0] op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] rd;
        logic        wr;
        logic        cmp;
        logic        carry;
        logic        err;
        int          lat;
        int          hold;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_ctrl_if bus ();

    alu_ctrl #(.TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: shifts complete after rs2[4:0] enabled cycles, others in the first one.
    logic [7:0]  lat_cnt;
    logic [31:0] m_res;
    logic [32:0] m_sum;
    logic [7:0]  m_lat;
    logic        m_ok;
    logic        m_rd;

    always @(posedge clk or negedge reset) begin
        if (!reset)               lat_cnt <= 8'd0;
        else if (!bus.alu_en)     lat_cnt <= 8'd0;
        else if (lat_cnt != 8'hFF) lat_cnt <= lat_cnt + 8'd1;
    end

    always_comb begin
        m_res         = 32'd0;
        m_sum         = 33'd0;
        m_lat         = 8'd0;
        m_ok          = 1'b1;
        m_rd          = 1'b1;
        bus.alu_cmp   = 1'b0;
        bus.alu_carry = 1'b0;
        case (bus.alu_decinst)
            OP_ADD: begin
                m_sum         = {1'b0, bus.alu_rs1} + {1'b0, bus.alu_rs2};
                m_res         = m_sum[31:0];
                bus.alu_carry = m_sum[32];
            end
            OP_BEQ: begin
                m_rd        = 1'b0;
                bus.alu_cmp = (bus.alu_rs1 == bus.alu_rs2);
            end
            OP_SLL: begin
                m_res = bus.alu_rs1 << bus.alu_rs2[4:0];
                m_lat = {3'd0, bus.alu_rs2[4:0]};
            end
            OP_XOR: m_res = bus.alu_rs1 ^ bus.alu_rs2;
            OP_SRA: begin
                m_res = 32'($signed(bus.alu_rs1) >>> bus.alu_rs2[4:0]);
                m_lat = {3'd0, bus.alu_rs2[4:0]};
            end
            default: begin
                m_ok = 1'b0;
                m_rd = 1'b0;
            end
        endcase
        bus.alu_is_inst = bus.alu_en && m_ok && (lat_cnt >= m_lat);
        bus.alu_is_rd   = bus.alu_is_inst && m_rd;
        // Junk pattern stands in for a floating rd bus when the ALU does not own it.
        bus.alu_rd      = bus.alu_is_rd ? m_res : 32'hA5A5_A5A5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({pfx, "_alu_en"},    32'(bus.alu_en),    32'd0);
        chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({pfx, "_rsp_rd"},    bus.rsp_rd,         32'd0);
        chk({pfx, "_rsp_flags"}, {28'd0, bus.rsp_wr, bus.rsp_cmp, bus.rsp_carry, bus.rsp_err}, 32'd0);
        chk({pfx, "_alu_dec"},   32'(bus.alu_decinst), 32'd0);
        chk({pfx, "_alu_ops"},   bus.alu_rs1 | bus.alu_rs2 | bus.alu_imm, 32'd0);
    endtask

    task automatic run_op(input vec_t v, input int id);
        string t;
        int    k;
        bit    seen;
        t = $sformatf("v%0d", id);
        @(negedge clk);
        chk({t, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.req_decinst = v.op;
        bus.req_rs1     = v.rs1;
        bus.req_rs2     = v.rs2;
        bus.req_imm     = v.imm;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk({t, "_load_en"},    32'(bus.alu_en),      32'd0);
        chk({t, "_load_ready"}, 32'(bus.req_ready),   32'd0);
        chk({t, "_load_dec"},   32'(bus.alu_decinst), 32'(v.op));
        chk({t, "_load_rs1"},   bus.alu_rs1,          v.rs1);
        chk({t, "_load_rs2"},   bus.alu_rs2,          v.rs2);
        @(negedge clk);
        chk({t, "_exec_en"},    32'(bus.alu_en),      32'd1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk({t, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(v.lat));
        chk({t, "_rd"},      bus.rsp_rd, v.rd);
        chk({t, "_flags"},   {28'd0, bus.rsp_wr, bus.rsp_cmp, bus.rsp_carry, bus.rsp_err},
                             {28'd0, v.wr, v.cmp, v.carry, v.err});
        chk({t, "_resp_en"},    32'(bus.alu_en),    32'd0);
        chk({t, "_resp_ready"}, 32'(bus.req_ready), 32'd0);
        for (int j = 0; j < v.hold; j++) begin
            bus.req_valid   = 1'b1;
            bus.req_decinst = 12'h5A5;
            bus.req_rs1     = 32'h1234_5678;
            @(posedge clk);
            @(negedge clk);
            chk({t, "_bp_valid"}, 32'(bus.rsp_valid),   32'd1);
            chk({t, "_bp_rd"},    bus.rsp_rd,           v.rd);
            chk({t, "_bp_ready"}, 32'(bus.req_ready),   32'd0);
            chk({t, "_bp_hold"},  32'(bus.alu_decinst), 32'(v.op));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk({t, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        chk({t, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   spurious;
        checks   = 0;
        failures = 0;
        //        op      rs1            rs2           imm    rd             wr    cmp   carry err   lat hold
        vecs[0] = '{OP_ADD, 32'd5,         32'd7,         32'd0, 32'd12,        1'b1, 1'b0, 1'b0, 1'b0, 1,  0};
        vecs[1] = '{OP_BEQ, 32'hDEADBEEF,  32'hDEADBEEF,  32'd0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1,  0};
        vecs[2] = '{OP_SLL, 32'd1,         32'd31,        32'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32, 0};
        vecs[3] = '{OP_XOR, 32'h0F,        32'hFF,        32'd0, 32'hF0,        1'b1, 1'b0, 1'b0, 1'b0, 1,  10};
        vecs[4] = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 1,  0};
        vecs[5] = '{OP_SRA, 32'h8000_0000, 32'd4,         32'd9, 32'hF800_0000, 1'b1, 1'b0, 1'b0, 1'b0, 5,  0};
        vecs[6] = '{OP_BAD, 32'h1111_1111, 32'h2222_2222, 32'd3, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1, 64, 0};
        vecs[7] = '{OP_BEQ, 32'd1,         32'd2,         32'd0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1,  0};

        reset           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_decinst = 12'd0;
        bus.req_rs1     = 32'd0;
        bus.req_rs2     = 32'd0;
        bus.req_imm     = 32'd0;
        bus.rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], i);
        end

        // Mid-EXEC reset during a long SRA: outputs clear at once and the op vanishes.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_decinst = OP_SRA;
        bus.req_rs1     = 32'h8000_0000;
        bus.req_rs2     = 32'd20;
        bus.req_imm     = 32'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("sra_in_exec", 32'(bus.alu_en), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset    = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) spurious++;
        end
        chk("no_rsp_after_rst", 32'(spurious), 32'd0);
        run_op('{OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0}, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
